// File: rtl/stream_mux2_rr.sv
// Two-source valid/ready stream merge with packet-granular round-robin arbitration
// and a single registered output stage (one cycle from input accept to out_valid).
module stream_mux2_rr #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_last,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_last,
   output logic             b_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_src,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_last_grant;   // 0 = A, 1 = B
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_last;
   logic             r_out_src;

   logic             w_space;
   logic             w_grant_a;
   logic             w_grant_b;
   logic             w_acc_a;
   logic             w_acc_b;
   logic             w_acc_last;

   assign w_space = !r_out_valid || out_ready;

   // IDLE with both valid goes to the source opposite the previous winner;
   // a lock grants its owner even while that owner is not valid.
   always_comb begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (a_valid && (!b_valid || r_last_grant))
               w_grant_a = 1'b1;
            else if (b_valid)
               w_grant_b = 1'b1;
         end
         LOCK_A:  w_grant_a = 1'b1;
         LOCK_B:  w_grant_b = 1'b1;
         default: ;
      endcase
   end

   assign a_ready    = w_space && w_grant_a;
   assign b_ready    = w_space && w_grant_b;
   assign w_acc_a    = a_valid && a_ready;
   assign w_acc_b    = b_valid && b_ready;
   assign w_acc_last = w_acc_b ? b_last : a_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_last   <= 1'b0;
         r_out_src    <= 1'b0;
      end else if (w_acc_a || w_acc_b) begin
         r_out_valid  <= 1'b1;
         r_out_data   <= w_acc_b ? b_data : a_data;
         r_out_last   <= w_acc_last;
         r_out_src    <= w_acc_b;
         r_last_grant <= w_acc_b;
         if (w_acc_last)
            r_state <= IDLE;
         else
            r_state <= w_acc_b ? LOCK_B : LOCK_A;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_src   = r_out_src;

endmodule

// File: tb/tb_stream_mux2_rr.sv
// Directed self-checking bench for stream_mux2_rr: readys checked mid-cycle,
// registered outputs checked 1 time unit after each rising edge.
module tb_stream_mux2_rr;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             a_valid, a_last, a_ready;
   logic [WIDTH-1:0] a_data;
   logic             b_valid, b_last, b_ready;
   logic [WIDTH-1:0] b_data;
   logic             out_valid, out_last, out_src, out_ready;
   logic [WIDTH-1:0] out_data;

   int unsigned n_cmp;
   int unsigned n_err;

   stream_mux2_rr #(.WIDTH(WIDTH)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_last    (a_last),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_last    (b_last),
      .b_ready   (b_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic av, input logic [7:0] ad, input logic al,
                        input logic bv, input logic [7:0] bd, input logic bl,
                        input logic ordy);
      a_valid   = av;
      a_data    = ad;
      a_last    = al;
      b_valid   = bv;
      b_data    = bd;
      b_last    = bl;
      out_ready = ordy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                          input logic l, input logic s);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".data"},  32'(out_data),  32'(d));
      chk({tag, ".last"},  32'(out_last),  32'(l));
      chk({tag, ".src"},   32'(out_src),   32'(s));
   endtask

   task automatic chk_rdy(input string tag, input logic ar, input logic br);
      chk({tag, ".a_ready"}, 32'(a_ready), 32'(ar));
      chk({tag, ".b_ready"}, 32'(b_ready), 32'(br));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [7:0] na, nb;

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;

      // Reset state
      do_reset();
      chk_out("rst", 0, 8'h00, 0, 0);
      chk_rdy("rst", 0, 0);

      // Single beat from A
      drive(1, 8'h11, 1, 0, 8'h00, 0, 1);
      chk_rdy("one", 1, 0);
      tick();
      chk_out("one", 1, 8'h11, 1, 0);
      drive(0, 8'h11, 1, 0, 8'h00, 0, 1);
      tick();
      chk_out("one_drain", 0, 8'h11, 1, 0);

      // Alternating single-beat packets, A first after reset
      do_reset();
      na = 8'hA0;
      nb = 8'hB0;
      for (int k = 0; k < 4; k++) begin
         drive(1, na, 1, 1, nb, 1, 1);
         chk_rdy($sformatf("alt%0d", k), (k % 2) == 0, (k % 2) == 1);
         tick();
         if ((k % 2) == 0) begin
            chk_out($sformatf("alt%0d", k), 1, na, 1, 0);
            na++;
         end else begin
            chk_out($sformatf("alt%0d", k), 1, nb, 1, 1);
            nb++;
         end
      end

      // A 3-beat packet holds the lock against a continuously valid B
      for (int j = 0; j < 3; j++) begin
         drive(1, 8'(j + 1), j == 2, 1, 8'hC5, 1, 1);
         chk_rdy($sformatf("lockA%0d", j), 1, 0);
         tick();
         chk_out($sformatf("lockA%0d", j), 1, 8'(j + 1), j == 2, 0);
      end
      drive(0, 8'h00, 0, 1, 8'hC5, 1, 1);
      chk_rdy("afterA", 0, 1);
      tick();
      chk_out("afterA", 1, 8'hC5, 1, 1);

      // Back-pressure for 3 cycles
      drive(1, 8'h33, 1, 0, 8'h00, 0, 1);
      tick();
      chk_out("bp_load", 1, 8'h33, 1, 0);
      for (int j = 0; j < 3; j++) begin
         drive(1, 8'h34, 1, 1, 8'h44, 1, 0);
         chk_rdy($sformatf("bp%0d", j), 0, 0);
         tick();
         chk_out($sformatf("bp%0d", j), 1, 8'h33, 1, 0);
      end
      drive(1, 8'h34, 1, 1, 8'h44, 1, 1);
      chk_rdy("bp_rel", 0, 1);
      tick();
      chk_out("bp_rel", 1, 8'h44, 1, 1);
      drive(1, 8'h34, 1, 0, 8'h00, 0, 1);
      chk_rdy("bp_rel2", 1, 0);
      tick();
      chk_out("bp_rel2", 1, 8'h34, 1, 0);
      drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
      tick();
      chk_out("bp_drain", 0, 8'h34, 1, 0);

      // A pauses mid-packet; B must stay blocked
      drive(1, 8'h51, 0, 0, 8'h00, 0, 1);
      chk_rdy("gap_b1", 1, 0);
      tick();
      chk_out("gap_b1", 1, 8'h51, 0, 0);
      for (int j = 0; j < 2; j++) begin
         drive(0, 8'h00, 0, 1, 8'h61, 1, 1);
         chk($sformatf("gap%0d.b_ready", j), 32'(b_ready), 32'(0));
         tick();
         chk($sformatf("gap%0d.valid", j), 32'(out_valid), 32'(0));
      end
      drive(1, 8'h52, 1, 1, 8'h61, 1, 1);
      chk_rdy("gap_b2", 1, 0);
      tick();
      chk_out("gap_b2", 1, 8'h52, 1, 0);
      drive(0, 8'h00, 0, 1, 8'h61, 1, 1);
      chk_rdy("gap_b", 0, 1);
      tick();
      chk_out("gap_b", 1, 8'h61, 1, 1);

      // Reset while B holds the lock with a beat in the output register
      drive(0, 8'h00, 0, 1, 8'h71, 0, 1);
      tick();
      chk_out("lockB", 1, 8'h71, 0, 1);
      rst = 1'b1;
      drive(1, 8'h81, 1, 1, 8'h72, 0, 1);
      tick();
      rst = 1'b0;
      chk_out("mid_rst", 0, 8'h00, 0, 0);
      drive(1, 8'h81, 1, 1, 8'h72, 0, 1);
      chk_rdy("post_rst", 1, 0);
      tick();
      chk_out("post_rst", 1, 8'h81, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
